mem_controller: RTL

Initiator for the 2048 x 64-bit RAM. Accepts one CPU load/store request at a time over a valid/ready handshake and sequences the RAM's level-sensitive port: address, `isReading`, write data, and read-data sampling. It returns a single response per request over a second valid/ready handshake. Sits between the datapath's memory stage and the RAM instance.

---
 rtl/mem_controller_pkg.sv | 26 ++
 rtl/mem_controller_cycle_timer.sv | 27 ++
 rtl/mem_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_controller_pkg.sv
// Shared definitions for the RAM initiator: FSM encodings, default widths,
// and the byte-address decode constants.
package mem_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RWAIT  = 3'd1,
        ST_WSETUP = 3'd2,
        ST_WPULSE = 3'd3,
        ST_WHOLD  = 3'd4,
        ST_RESP   = 3'd5
    } memState_e;

    localparam int DEFAULT_ADDR_WIDTH = 11;
    localparam int DEFAULT_DATA_WIDTH = 64;

    // Byte address bits 13:3 select the word; everything else must be zero.
    localparam int WORD_LSB = 3;
    localparam int WORD_MSB = 13;
    localparam logic [63:0] ADDR_ERR_MASK = 64'hFFFF_FFFF_FFFF_C007;

    function automatic logic addrError(input logic [63:0] addr);
        return |(addr & ADDR_ERR_MASK);
    endfunction

endpackage

// File: rtl/mem_controller_cycle_timer.sv
// 4-bit loadable down-counter; done while the count is zero.
// Shared by the read-wait and write-pulse phases of the controller.
module cycle_timer (
    input  logic       clk,
    input  logic       resetN,
    input  logic       load,
    input  logic [3:0] loadValue,
    input  logic       enable,
    output logic       done
);

    logic [3:0] count_r;

    // Counter register: load has priority over decrement, stops at zero.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= loadValue;
        end else if (enable && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end
    end

    assign done = (count_r == 4'd0);

endmodule

// File: rtl/mem_controller.sv
// Single-outstanding load/store initiator for the 2048 x 64-bit RAM.
// Drives the RAM's level-sensitive port and returns one response per request.
module mem_controller
    import mem_controller_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int READ_WAIT   = 1,
    parameter int WRITE_PULSE = 2
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [63:0]           reqAddr,
    input  logic [63:0]           reqData,
    output logic                  respValid,
    input  logic                  respReady,
    output logic [63:0]           respData,
    output logic                  respError,
    output logic [ADDR_WIDTH-1:0] ramAddress,
    output logic                  ramIsReading,
    output logic [DATA_WIDTH-1:0] ramDataIn,
    input  logic [DATA_WIDTH-1:0] ramDataOut
);

    memState_e             state_r;
    memState_e             nextState_s;
    logic                  accept_s;
    logic                  reqError_s;
    logic                  timerLoad_s;
    logic [3:0]            timerLoadValue_s;
    logic                  timerEnable_s;
    logic                  timerDone_s;

    logic                  ramIsReading_r;
    logic [ADDR_WIDTH-1:0] ramAddress_r;
    logic [DATA_WIDTH-1:0] ramDataIn_r;
    logic                  respValid_r;
    logic [63:0]           respData_r;
    logic                  respError_r;

    // Ready is combinational so it drops the moment reset is asserted.
    assign reqReady   = resetN && (state_r == ST_IDLE);
    assign accept_s   = reqValid && (state_r == ST_IDLE);
    assign reqError_s = addrError(reqAddr);

    cycle_timer u_cycle_timer (
        .clk       (clk),
        .resetN    (resetN),
        .load      (timerLoad_s),
        .loadValue (timerLoadValue_s),
        .enable    (timerEnable_s),
        .done      (timerDone_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic and timer control.
    always_comb begin
        nextState_s      = state_r;
        timerLoad_s      = 1'b0;
        timerLoadValue_s = 4'd0;
        timerEnable_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (reqError_s) begin
                        nextState_s = ST_RESP;
                    end else if (reqWrite) begin
                        nextState_s = ST_WSETUP;
                    end else begin
                        nextState_s      = ST_RWAIT;
                        timerLoad_s      = 1'b1;
                        timerLoadValue_s = 4'(READ_WAIT - 1);
                    end
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_RWAIT: begin
                if (timerDone_s) begin
                    nextState_s = ST_RESP;
                end else begin
                    timerEnable_s = 1'b1;
                end
            end
            ST_WSETUP: begin
                nextState_s      = ST_WPULSE;
                timerLoad_s      = 1'b1;
                timerLoadValue_s = 4'(WRITE_PULSE - 1);
            end
            ST_WPULSE: begin
                if (timerDone_s) begin
                    nextState_s = ST_WHOLD;
                end else begin
                    timerEnable_s = 1'b1;
                end
            end
            ST_WHOLD: begin
                nextState_s = ST_RESP;
            end
            ST_RESP: begin
                if (respReady) begin
                    nextState_s = ST_IDLE;
                end else begin
                    nextState_s = ST_RESP;
                end
            end
            default: begin
                nextState_s = ST_IDLE;
            end
        endcase
    end

    // Output registers; RAM address/data move only when a good request is accepted.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            ramIsReading_r <= 1'b1;
            ramAddress_r   <= '0;
            ramDataIn_r    <= '0;
            respValid_r    <= 1'b0;
            respData_r     <= 64'd0;
            respError_r    <= 1'b0;
        end else begin
            ramIsReading_r <= (nextState_s != ST_WPULSE);
            respValid_r    <= (nextState_s == ST_RESP);
            if (accept_s) begin
                respData_r  <= 64'd0;
                respError_r <= reqError_s;
                if (!reqError_s) begin
                    ramAddress_r <= ADDR_WIDTH'(reqAddr[WORD_MSB:WORD_LSB]);
                    ramDataIn_r  <= reqData[DATA_WIDTH-1:0];
                end
            end else if ((state_r == ST_RWAIT) && timerDone_s) begin
                respData_r <= 64'(ramDataOut);
            end
        end
    end

    assign ramIsReading = ramIsReading_r;
    assign ramAddress   = ramAddress_r;
    assign ramDataIn    = ramDataIn_r;
    assign respValid    = respValid_r;
    assign respData     = respData_r;
    assign respError    = respError_r;

endmodule
